// File: rtl/shift_right_iter.sv
// shift_right_iter: multi-cycle right shifter for the execute stage.
// Runs one barrel stage per clock (16, 8, 4, 2, 1 bits). The shift amount
// is captured on a start pulse, and the result comes back as a one-cycle
// ready pulse five cycles later.
// op: 00 SRL, 01 SRA, 10 ROTR (needs SHIFT_RIGHT_ITER_ROTR_EN, otherwise SRL),
//     11 reserved (SRL).
// Optional macro: SHIFT_RIGHT_ITER_ROTR_EN enables rotate-right on op 10.
module shift_right_iter #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [1:0]  op,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amt_q, amt_d;
  logic        fill_q, fill_d;
  logic [2:0]  stage_q, stage_d;
  logic [31:0] result_q, result_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
`ifdef SHIFT_RIGHT_ITER_ROTR_EN
  logic        rotr_q, rotr_d;
  logic [31:0] wrap_bits;
`endif

  logic [4:0]  stage_amt;
  logic [31:0] shifted;
  logic [31:0] fill_mask;
  logic [31:0] stage_out;

  // One barrel stage: shift the working value by 16 >> stage, filling the
  // vacated top bits with the captured fill bit or the bits rotated out.
  always_comb begin
    stage_amt = 5'd16 >> stage_q;
    shifted   = work_q >> stage_amt;
    fill_mask = ~(32'hFFFF_FFFF >> stage_amt);
`ifdef SHIFT_RIGHT_ITER_ROTR_EN
    wrap_bits = work_q << (6'd32 - {1'b0, stage_amt});
    if (rotr_q) begin
      stage_out = shifted | wrap_bits;
    end else begin
      stage_out = shifted | (fill_q ? fill_mask : 32'h0);
    end
`else
    stage_out = shifted | (fill_q ? fill_mask : 32'h0);
`endif
  end

  // Next-state logic. The captured amount is shifted left once per stage,
  // so bit 4 is always the shamt bit that belongs to the current stage.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    fill_d   = fill_q;
    stage_d  = stage_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
`ifdef SHIFT_RIGHT_ITER_ROTR_EN
    rotr_d   = rotr_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctrl_shift) begin
          work_d  = data_operandA;
          amt_d   = shamt;
          fill_d  = (op == 2'b01) & data_operandA[31];
`ifdef SHIFT_RIGHT_ITER_ROTR_EN
          rotr_d  = (op == 2'b10);
`endif
          stage_d = 3'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (amt_q[4]) begin
          work_d = stage_out;
        end
        amt_d   = {amt_q[3:0], 1'b0};
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'd4) begin
          result_d = work_d;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          stage_d  = 3'd0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any
  // operation in flight without producing a ready pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      work_q   <= 32'h0;
      amt_q    <= 5'h0;
      fill_q   <= 1'b0;
      stage_q  <= 3'd0;
      result_q <= 32'h0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SHIFT_RIGHT_ITER_ROTR_EN
      rotr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amt_q    <= amt_d;
      fill_q   <= fill_d;
      stage_q  <= stage_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef SHIFT_RIGHT_ITER_ROTR_EN
      rotr_q   <= rotr_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// tb_shift_right_iter: directed, table-driven bench for shift_right_iter.
// Expected values are hand-computed; rotate rows depend on whether
// SHIFT_RIGHT_ITER_ROTR_EN is defined.
module tb_shift_right_iter;

  logic        clock;
  logic        reset;
  logic        ctrl_shift;
  logic [1:0]  op;
  logic [31:0] data_operandA;
  logic [4:0]  shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] expected;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  shift_right_iter #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_shift(ctrl_shift),
    .op(op),
    .data_operandA(data_operandA),
    .shamt(shamt),
    .data_result(data_result),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge: drives the start pulse across the next rising edge
  // and returns at the negedge just after the capture edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [4:0] s);
    op            = o;
    data_operandA = a;
    shamt         = s;
    ctrl_shift    = 1'b1;
    @(negedge clock);
    ctrl_shift    = 1'b0;
    data_operandA = 32'hDEAD_0000;
    shamt         = 5'd13;
    op            = 2'b01;
  endtask

  // Waits (bounded) for the ready pulse, counting negedges since the
  // capture edge, and checks latency, busy duration and result.
  task automatic waitResult(input string name, input int startCnt,
                            input logic [31:0] expected);
    int cnt;
    int busyHigh;
    cnt      = startCnt;
    busyHigh = 0;
    while (!data_resultRDY && cnt < 20) begin
      if (busy) busyHigh++;
      @(negedge clock);
      cnt++;
    end
    checkOutput({name, "_latency"}, 32'(cnt), 32'd5);
    checkOutput({name, "_busycycles"}, 32'(busyHigh), 32'(5 - startCnt));
    checkOutput({name, "_busy_at_rdy"}, {31'h0, busy}, 32'h0);
    checkOutput({name, "_result"}, data_result, expected);
  endtask

  initial begin
    int rdyCount;
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    ctrl_shift    = 1'b0;
    op            = 2'b00;
    data_operandA = 32'h0;
    shamt         = 5'd0;

    vecs[0]  = '{2'b00, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[1]  = '{2'b01, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b01, 32'h8000_0001, 5'd16, 32'hFFFF_8000};
    vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 5'd12, 32'h000D_EADB};
    vecs[4]  = '{2'b11, 32'h8000_0000, 5'd1,  32'h4000_0000};
    vecs[5]  = '{2'b01, 32'h4000_0000, 5'd30, 32'h0000_0001};
    vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 5'd5,  32'h07FF_FFFF};
    vecs[7]  = '{2'b01, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
    vecs[8]  = '{2'b00, 32'hA5A5_A5A5, 5'd21, 32'h0000_052D};
`ifdef SHIFT_RIGHT_ITER_ROTR_EN
    vecs[9]  = '{2'b10, 32'h0000_0001, 5'd1,  32'h8000_0000};
    vecs[10] = '{2'b10, 32'h0000_00AB, 5'd8,  32'hAB00_0000};
    vecs[11] = '{2'b10, 32'h1234_5678, 5'd12, 32'h6781_2345};
    vecs[12] = '{2'b10, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[13] = '{2'b10, 32'hF000_000F, 5'd31, 32'hE000_001F};
`else
    vecs[9]  = '{2'b10, 32'h0000_0001, 5'd1,  32'h0000_0000};
    vecs[10] = '{2'b10, 32'h0000_00AB, 5'd8,  32'h0000_0000};
    vecs[11] = '{2'b10, 32'h1234_5678, 5'd12, 32'h0001_2345};
    vecs[12] = '{2'b10, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[13] = '{2'b10, 32'hF000_000F, 5'd31, 32'h0000_0001};
`endif

    // Reset held low for two edges, then released.
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    checkOutput("reset_result", data_result, 32'h0);
    checkOutput("reset_rdy", {31'h0, data_resultRDY}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    rdyCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdyCount++;
    end
    checkOutput("idle_no_rdy", 32'(rdyCount), 32'd0);

    // Table-driven vectors, one operation at a time.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].shamt);
      waitResult($sformatf("vec%0d", i), 0, vecs[i].expected);
      @(negedge clock);
      checkOutput($sformatf("vec%0d_rdy_pulse", i), {31'h0, data_resultRDY}, 32'h0);
      checkOutput($sformatf("vec%0d_result_held", i), data_result, vecs[i].expected);
    end

    // Back-to-back SRA: the second start is issued in the ready cycle.
    @(negedge clock);
    applyStimulus(2'b01, 32'h8000_0000, 5'd4);
    waitResult("sra_neg", 0, 32'hF800_0000);
    applyStimulus(2'b01, 32'h7FFF_FFF0, 5'd4);
    checkOutput("b2b_rdy_drop", {31'h0, data_resultRDY}, 32'h0);
    checkOutput("b2b_busy_rise", {31'h0, busy}, 32'h1);
    checkOutput("b2b_result_held", data_result, 32'hF800_0000);
    waitResult("sra_pos_b2b", 0, 32'h07FF_FFFF);

    // shamt = 0 with a second start pulsed while busy.
    @(negedge clock);
    @(negedge clock);
    applyStimulus(2'b00, 32'h1234_5678, 5'd0);
    @(negedge clock);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 5'd31);
    waitResult("shamt0_busy_start", 2, 32'h1234_5678);
    rdyCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdyCount++;
    end
    checkOutput("ignored_start_no_rdy", 32'(rdyCount), 32'd0);
    checkOutput("ignored_start_result", data_result, 32'h1234_5678);

    // Reset at the third SHIFT edge aborts the operation.
    @(negedge clock);
    applyStimulus(2'b00, 32'hFFFF_FFFF, 5'd8);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    checkOutput("abort_rdy", {31'h0, data_resultRDY}, 32'h0);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    checkOutput("abort_result", data_result, 32'h0);
    rdyCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdyCount++;
    end
    checkOutput("abort_no_rdy", 32'(rdyCount), 32'd0);
    checkOutput("abort_result_stays", data_result, 32'h0);
    applyStimulus(2'b00, 32'hFFFF_FFFF, 5'd8);
    waitResult("after_abort", 0, 32'h00FF_FFFF);

    // Reset wins over a start pulse at the same edge.
    @(negedge clock);
    reset         = 1'b0;
    applyStimulus(2'b00, 32'h0000_00F0, 5'd4);
    reset = 1'b1;
    checkOutput("reset_vs_start_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_vs_start_result", data_result, 32'h0);
    rdyCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdyCount++;
    end
    checkOutput("reset_vs_start_no_rdy", 32'(rdyCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
